haar_lift_unit: RTL and testbench



---
 rtl/haar_lift_pkg.sv | 19 +
 rtl/haar_lift_unit_step.sv | 26 ++
 rtl/haar_lift_unit.sv | 72 +++++++
 tb/tb_haar_lift_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/haar_lift_pkg.sv
// Shared types and helpers for the one-level integer Haar lifting engine.
package haar_lift_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef logic signed [DATA_W_DEF:0]   wide_t;

  // Clamp a full-precision detail value into the signed sample range.
  function automatic sample_t sat_narrow(input wide_t w);
    sample_t r;
    r = w[DATA_W_DEF-1:0];
    if (w[DATA_W_DEF] != w[DATA_W_DEF-1]) begin
      r = {w[DATA_W_DEF], {(DATA_W_DEF-1){~w[DATA_W_DEF]}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/haar_lift_unit_step.sv
// Combinational lifting step: predict d = odd - even, update a = even + floor(d/2).
module haar_lift_step
  import haar_lift_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] even,
  input  logic signed [DATA_W-1:0] odd,
  output logic signed [DATA_W:0]   d17,
  output logic signed [DATA_W-1:0] a
);

  logic signed [DATA_W:0] even_w;
  logic signed [DATA_W:0] odd_w;
  logic signed [DATA_W:0] half_w;
  logic signed [DATA_W:0] sum_w;

  // Sign-extend into one extra bit so the difference can never overflow.
  assign even_w = {even[DATA_W-1], even};
  assign odd_w  = {odd[DATA_W-1], odd};
  assign d17    = odd_w - even_w;
  assign half_w = d17 >>> 1;
  assign sum_w  = even_w + half_w;
  assign a      = sum_w[DATA_W-1:0];

endmodule

// File: rtl/haar_lift_unit.sv
// Two-stage Haar lifting pipeline with a valid chain.
// Define HAAR_LIFT_SAT_EN to saturate the detail output instead of wrapping it.
module haar_lift_unit
  import haar_lift_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] im11,
  input  logic signed [DATA_W-1:0] im21,
  output logic signed [DATA_W-1:0] dxy_detail,
  output logic signed [DATA_W-1:0] dxy_approx,
  output logic                     data_occur
);

  logic signed [DATA_W:0]   d17_c;
  logic signed [DATA_W-1:0] a_c;
  logic signed [DATA_W:0]   d17_q;
  logic signed [DATA_W-1:0] a_q;
  logic                     v_q;
  logic signed [DATA_W-1:0] d_narrow_c;

  haar_lift_step #(.DATA_W(DATA_W)) u_step (
    .even (im11),
    .odd  (im21),
    .d17  (d17_c),
    .a    (a_c)
  );

  // Stage 1: capture the lifted pair and its valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d17_q <= '0;
      a_q   <= '0;
      v_q   <= 1'b0;
    end else begin
      v_q <= start;
      if (start) begin
        d17_q <= d17_c;
        a_q   <= a_c;
      end
    end
  end

  // Reduce the full-precision detail to the output width.
  always_comb begin
    d_narrow_c = d17_q[DATA_W-1:0];
`ifdef HAAR_LIFT_SAT_EN
    if (d17_q[DATA_W] != d17_q[DATA_W-1]) begin
      d_narrow_c = {d17_q[DATA_W], {(DATA_W-1){~d17_q[DATA_W]}}};
    end
`endif
  end

  // Stage 2: outputs only move on a valid pair, otherwise they hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dxy_detail <= '0;
      dxy_approx <= '0;
      data_occur <= 1'b0;
    end else begin
      data_occur <= v_q;
      if (v_q) begin
        dxy_detail <= d_narrow_c;
        dxy_approx <= a_q;
      end
    end
  end

endmodule

// File: tb/tb_haar_lift_unit.sv
// Scoreboard bench for haar_lift_unit (default or HAAR_LIFT_SAT_EN build).
module tb_haar_lift_unit;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] im11;
  logic [W-1:0] im21;
  logic [W-1:0] dxy_detail;
  logic [W-1:0] dxy_approx;
  logic         data_occur;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q_d[$];
  logic [W-1:0] q_a[$];
  logic         m_v1 = 1'b0;
  logic         m_v2 = 1'b0;

  always #5 clk = ~clk;

  haar_lift_unit #(.DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .im11       (im11),
    .im21       (im21),
    .dxy_detail (dxy_detail),
    .dxy_approx (dxy_approx),
    .data_occur (data_occur)
  );

  function automatic logic [W-1:0] ref_d(input logic [W-1:0] e, input logic [W-1:0] o);
    int d;
    d = int'($signed(o)) - int'($signed(e));
`ifdef HAAR_LIFT_SAT_EN
    if (d > 32767) d = 32767;
    else if (d < -32768) d = -32768;
`endif
    return W'(d);
  endfunction

  function automatic logic [W-1:0] ref_a(input logic [W-1:0] e, input logic [W-1:0] o);
    int d;
    int h;
    d = int'($signed(o)) - int'($signed(e));
    h = (d >= 0) ? d / 2 : -((-d + 1) / 2);
    return W'(int'($signed(e)) + h);
  endfunction

  task automatic drive(input logic s, input logic [W-1:0] e, input logic [W-1:0] o,
                       input logic [W-1:0] ed, input logic [W-1:0] ea);
    start = s;
    im11  = e;
    im21  = o;
    if (s) begin
      q_d.push_back(ed);
      q_a.push_back(ea);
    end
  endtask

  // Advance one clock and update the expected valid pipeline.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_v1 = 1'b0;
      m_v2 = 1'b0;
    end else begin
      m_v2 = m_v1;
      m_v1 = start;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, W'($urandom), W'($urandom), '0, '0);
      start = 1'b1;
      tick();
      checks++;
      if (data_occur !== 1'b0 || dxy_detail !== '0 || dxy_approx !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got v=%b d=%h a=%h want v=0 d=0000 a=0000",
                 i, data_occur, dxy_detail, dxy_approx);
      end
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] te[5];
    logic [W-1:0] to[5];
    logic [W-1:0] td[5];
    logic [W-1:0] ta[5];
    logic [W-1:0] ed;
    logic [W-1:0] ea;
    te = '{16'd10, 16'd14, 16'd7, 16'd8, 16'h8000};
    to = '{16'd14, 16'd10, 16'd8, 16'd7, 16'h7FFF};
`ifdef HAAR_LIFT_SAT_EN
    td = '{16'h0004, 16'hFFFC, 16'h0001, 16'hFFFF, 16'h7FFF};
`else
    td = '{16'h0004, 16'hFFFC, 16'h0001, 16'hFFFF, 16'hFFFF};
`endif
    ta = '{16'd12, 16'd12, 16'd7, 16'd7, 16'hFFFF};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, te[i], to[i], td[i], ta[i]);
      for (int c = 0; c < 3; c++) begin
        tick();
        if (c == 0) drive(1'b0, '0, '0, '0, '0);
        checks++;
        if (data_occur !== m_v2) begin
          errors++;
          $display("FAIL basic_valid pair %0d cyc %0d got %b want %b", i, c, data_occur, m_v2);
        end
        if (data_occur === 1'b1) begin
          checks++;
          if (q_d.size() == 0) begin
            errors++;
            $display("FAIL basic_extra pair %0d got unexpected output want none", i);
          end else begin
            ed = q_d.pop_front();
            ea = q_a.pop_front();
            if (dxy_detail !== ed) begin
              errors++;
              $display("FAIL basic_detail pair %0d got %h want %h", i, dxy_detail, ed);
            end
            checks++;
            if (dxy_approx !== ea) begin
              errors++;
              $display("FAIL basic_approx pair %0d got %h want %h", i, dxy_approx, ea);
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ed;
    logic [W-1:0] ea;
    logic [W-1:0] last_d;
    logic [W-1:0] last_a;
    int pulses = 0;
    int run = 0;
    int max_run = 0;
    int zeros = 0;
    int gap = 0;
    bit seen = 1'b0;
    last_d = dxy_detail;
    last_a = dxy_approx;
    for (int cyc = 0; cyc < 133; cyc++) begin
      if (cyc < 128) drive(1'b1, W'(2 * cyc), W'(2 * cyc + 1), 16'd1, W'(2 * cyc));
      else if (cyc == 129) drive(1'b1, 16'd256, 16'd257, 16'd1, 16'd256);
      else drive(1'b0, '0, '0, '0, '0);
      tick();
      checks++;
      if (data_occur !== m_v2) begin
        errors++;
        $display("FAIL stream_valid cyc %0d got %b want %b", cyc, data_occur, m_v2);
      end
      if (data_occur === 1'b1) begin
        pulses++;
        run++;
        if (run > max_run) max_run = run;
        if (seen) gap += zeros;
        zeros = 0;
        seen = 1'b1;
        checks++;
        if (q_d.size() == 0) begin
          errors++;
          $display("FAIL stream_extra cyc %0d got unexpected output want none", cyc);
        end else begin
          ed = q_d.pop_front();
          ea = q_a.pop_front();
          if (dxy_detail !== ed || dxy_approx !== ea) begin
            errors++;
            $display("FAIL stream_data cyc %0d got d=%h a=%h want d=%h a=%h",
                     cyc, dxy_detail, dxy_approx, ed, ea);
          end
        end
        last_d = dxy_detail;
        last_a = dxy_approx;
      end else begin
        run = 0;
        if (seen) zeros++;
        checks++;
        if (dxy_detail !== last_d || dxy_approx !== last_a) begin
          errors++;
          $display("FAIL stream_hold cyc %0d got d=%h a=%h want d=%h a=%h",
                   cyc, dxy_detail, dxy_approx, last_d, last_a);
        end
      end
    end
    checks++;
    if (pulses != 129 || max_run != 128 || gap != 1) begin
      errors++;
      $display("FAIL stream_shape got pulses=%0d run=%0d gap=%0d want pulses=129 run=128 gap=1",
               pulses, max_run, gap);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] e;
    logic [W-1:0] o;
    logic [W-1:0] ed;
    logic [W-1:0] ea;
    for (int i = 0; i < 6; i++) begin
      e = W'($urandom);
      o = W'($urandom);
      drive(1'b1, e, o, ref_d(e, o), ref_a(e, o));
      tick();
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (data_occur !== 1'b0 || dxy_detail !== '0 || dxy_approx !== '0) begin
      errors++;
      $display("FAIL midreset_async got v=%b d=%h a=%h want v=0 d=0000 a=0000",
               data_occur, dxy_detail, dxy_approx);
    end
    q_d.delete();
    q_a.delete();
    drive(1'b0, '0, '0, '0, '0);
    tick();
    tick();
    reset = 1'b1;
    e = 16'h1234;
    o = 16'h0FF1;
    drive(1'b1, e, o, ref_d(e, o), ref_a(e, o));
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) drive(1'b0, '0, '0, '0, '0);
      checks++;
      if (data_occur !== m_v2) begin
        errors++;
        $display("FAIL midreset_valid cyc %0d got %b want %b", c, data_occur, m_v2);
      end
      if (data_occur === 1'b1) begin
        checks++;
        if (q_d.size() == 0) begin
          errors++;
          $display("FAIL midreset_extra cyc %0d got stale output want none", c);
        end else begin
          ed = q_d.pop_front();
          ea = q_a.pop_front();
          if (dxy_detail !== ed || dxy_approx !== ea) begin
            errors++;
            $display("FAIL midreset_data got d=%h a=%h want d=%h a=%h",
                     dxy_detail, dxy_approx, ed, ea);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (q_d.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q_d.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
